// File: rtl/mem_wb_stage_if.sv
// MEM->WB handshake, data-bus response and register-file write port of the writeback stage.
interface mem_wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              mem_valid_i;
    logic              mem_ready_o;
    logic              flush_i;
    logic              mem_wreg_i;
    logic [ADDR_W-1:0] mem_waddr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_load_i;
    logic [2:0]        mem_load_type_i;
    logic [1:0]        mem_addr_low_i;
    logic [DATA_W-1:0] mem_rt_data_i;
    logic              dbus_rvalid_i;
    logic [DATA_W-1:0] dbus_rdata_i;
    logic              stall_req_o;
    logic              write_en_o;
    logic [ADDR_W-1:0] write_addr_o;
    logic [DATA_W-1:0] write_data_o;

    // Environment side: MEM stage, data bus and register file.
    modport master (
        output mem_valid_i, flush_i, mem_wreg_i, mem_waddr_i, mem_wdata_i, mem_load_i,
               mem_load_type_i, mem_addr_low_i, mem_rt_data_i, dbus_rvalid_i, dbus_rdata_i,
        input  mem_ready_o, stall_req_o, write_en_o, write_addr_o, write_data_o
    );

    modport slave (
        input  mem_valid_i, flush_i, mem_wreg_i, mem_waddr_i, mem_wdata_i, mem_load_i,
               mem_load_type_i, mem_addr_low_i, mem_rt_data_i, dbus_rvalid_i, dbus_rdata_i,
        output mem_ready_o, stall_req_o, write_en_o, write_addr_o, write_data_o
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data, aligns/merges it
// and presents a single-cycle register-file write.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StWaitLoad, StWrite} state_e;

    state_e            state_q, state_d;
    logic              wreg_q, wreg_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        load_type_q, load_type_d;
    logic [1:0]        addr_low_q, addr_low_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic              ready;
    logic              accept;

    // Little-endian byte/half extraction plus the unaligned LWL/LWR merges with old rt.
    function automatic logic [31:0] align(input logic [31:0] rd, input logic [2:0] lt,
                                          input logic [1:0] off, input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(rd >> {off, 3'b000});
        h = off[1] ? rd[31:16] : rd[15:0];
        case (lt)
            3'd0: res = {{24{b[7]}}, b};
            3'd1: res = {24'b0, b};
            3'd2: res = {{16{h[15]}}, h};
            3'd3: res = {16'b0, h};
            3'd5: begin
                case (off)
                    2'd0:    res = {rd[7:0], rt[23:0]};
                    2'd1:    res = {rd[15:0], rt[15:0]};
                    2'd2:    res = {rd[23:0], rt[7:0]};
                    default: res = rd;
                endcase
            end
            3'd6: begin
                case (off)
                    2'd0:    res = rd;
                    2'd1:    res = {rt[31:24], rd[31:8]};
                    2'd2:    res = {rt[31:16], rd[31:16]};
                    default: res = {rt[31:8], rd[31:24]};
                endcase
            end
            default: res = rd;
        endcase
        return res;
    endfunction

    assign ready  = (state_q != StWaitLoad);
    assign accept = bus.mem_valid_i && ready && !bus.flush_i;

    always_comb begin
        state_d     = state_q;
        wreg_d      = wreg_q;
        waddr_d     = waddr_q;
        data_d      = data_q;
        load_type_d = load_type_q;
        addr_low_d  = addr_low_q;
        rt_data_d   = rt_data_q;
        case (state_q)
            StIdle, StWrite: begin
                if (accept) begin
                    wreg_d      = bus.mem_wreg_i;
                    waddr_d     = bus.mem_waddr_i;
                    load_type_d = bus.mem_load_type_i;
                    addr_low_d  = bus.mem_addr_low_i;
                    rt_data_d   = bus.mem_rt_data_i;
                    if (!bus.mem_load_i) begin
                        data_d  = bus.mem_wdata_i;
                        state_d = StWrite;
                    end else if (bus.dbus_rvalid_i) begin
                        data_d  = align(bus.dbus_rdata_i, bus.mem_load_type_i,
                                        bus.mem_addr_low_i, bus.mem_rt_data_i);
                        state_d = StWrite;
                    end else begin
                        state_d = StWaitLoad;
                    end
                end else if (state_q == StWrite) begin
                    state_d = StIdle;
                end
            end
            StWaitLoad: begin
                if (bus.dbus_rvalid_i) begin
                    data_d  = align(bus.dbus_rdata_i, load_type_q, addr_low_q, rt_data_q);
                    state_d = StWrite;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wreg_q      <= 1'b0;
            waddr_q     <= '0;
            data_q      <= '0;
            load_type_q <= '0;
            addr_low_q  <= '0;
            rt_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wreg_q      <= wreg_d;
            waddr_q     <= waddr_d;
            data_q      <= data_d;
            load_type_q <= load_type_d;
            addr_low_q  <= addr_low_d;
            rt_data_q   <= rt_data_d;
        end
    end

    // Register-file port is quiet outside WRITE so downstream sees clean zeros.
    always_comb begin
        bus.mem_ready_o  = ready;
        bus.stall_req_o  = !ready;
        bus.write_en_o   = (state_q == StWrite) && wreg_q && (waddr_q != '0);
        bus.write_addr_o = (state_q == StWrite) ? waddr_q : '0;
        bus.write_data_o = (state_q == StWrite) ? data_q : '0;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected register writes queued on stimulus, popped on write.
module tb_mem_wb_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    logic [4:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    mem_wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Any asserted write must match the oldest expected one.
    task automatic sample_wb();
        logic [4:0]  ea;
        logic [31:0] ed;
        if (bus.write_en_o === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write_en", 32'(bus.write_en_o), 32'd0);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                chk("wb_addr", 32'(bus.write_addr_o), 32'(ea));
                chk("wb_data", bus.write_data_o, ed);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        sample_wb();
    endtask

    task automatic idle_inputs();
        bus.mem_valid_i     = 1'b0;
        bus.flush_i         = 1'b0;
        bus.mem_wreg_i      = 1'b0;
        bus.mem_waddr_i     = '0;
        bus.mem_wdata_i     = '0;
        bus.mem_load_i      = 1'b0;
        bus.mem_load_type_i = '0;
        bus.mem_addr_low_i  = '0;
        bus.mem_rt_data_i   = '0;
        bus.dbus_rvalid_i   = 1'b0;
        bus.dbus_rdata_i    = '0;
    endtask

    task automatic drive_alu(input logic [4:0] wa, input logic [31:0] wd);
        bus.mem_valid_i = 1'b1;
        bus.mem_wreg_i  = 1'b1;
        bus.mem_load_i  = 1'b0;
        bus.mem_waddr_i = wa;
        bus.mem_wdata_i = wd;
        if (wa != 5'd0) push(wa, wd);
    endtask

    // Load with rvalid first seen k cycles after the accept edge (k=0: same cycle).
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                           input logic [4:0] wa, input logic wr, input logic [31:0] rt,
                           input logic [31:0] rd, input logic [31:0] exp, input int k);
        logic writes;
        writes = wr && (wa != 5'd0);
        bus.mem_valid_i     = 1'b1;
        bus.mem_load_i      = 1'b1;
        bus.mem_wreg_i      = wr;
        bus.mem_waddr_i     = wa;
        bus.mem_load_type_i = lt;
        bus.mem_addr_low_i  = off;
        bus.mem_rt_data_i   = rt;
        bus.dbus_rvalid_i   = (k == 0);
        bus.dbus_rdata_i    = rd;
        if (writes) push(wa, exp);
        cyc();
        idle_inputs();
        for (int i = 1; i <= k; i++) begin
            chk({tag, "_stall"}, 32'(bus.stall_req_o), 32'd1);
            chk({tag, "_ready"}, 32'(bus.mem_ready_o), 32'd0);
            chk({tag, "_we_wait"}, 32'(bus.write_en_o), 32'd0);
            if (i == k) begin
                bus.dbus_rvalid_i = 1'b1;
                bus.dbus_rdata_i  = rd;
            end
            cyc();
            idle_inputs();
        end
        chk({tag, "_stall_done"}, 32'(bus.stall_req_o), 32'd0);
        chk({tag, "_we"}, 32'(bus.write_en_o), 32'(writes));
        cyc();
        chk({tag, "_we_after"}, 32'(bus.write_en_o), 32'd0);
    endtask

    initial begin
        idle_inputs();
        #3;
        chk("rst_ready", 32'(bus.mem_ready_o), 32'd1);
        chk("rst_stall", 32'(bus.stall_req_o), 32'd0);
        chk("rst_we", 32'(bus.write_en_o), 32'd0);
        chk("rst_addr", 32'(bus.write_addr_o), 32'd0);
        chk("rst_data", bus.write_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // ALU back-to-back
        drive_alu(5'd3, 32'h11);
        cyc();
        chk("alu1_we", 32'(bus.write_en_o), 32'd1);
        chk("alu1_ready", 32'(bus.mem_ready_o), 32'd1);
        drive_alu(5'd4, 32'h22);
        cyc();
        chk("alu2_we", 32'(bus.write_en_o), 32'd1);
        chk("alu2_ready", 32'(bus.mem_ready_o), 32'd1);
        idle_inputs();
        cyc();
        chk("alu_idle_we", 32'(bus.write_en_o), 32'd0);

        // Sign/zero extension with waits
        do_load("lb",  3'd0, 2'd3, 5'd5, 1'b1, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80, 2);
        do_load("lbu", 3'd1, 2'd3, 5'd5, 1'b1, 32'h0, 32'h80FF_1234, 32'h0000_0080, 2);
        // Merges
        do_load("lwl1", 3'd5, 2'd1, 5'd8, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 1);
        do_load("lwr1", 3'd6, 2'd1, 5'd8, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233, 1);
        do_load("lwl0", 3'd5, 2'd0, 5'd9, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD, 0);
        do_load("lwl2", 3'd5, 2'd2, 5'd9, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD, 3);
        do_load("lwl3", 3'd5, 2'd3, 5'd9, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1);
        do_load("lwr0", 3'd6, 2'd0, 5'd10, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1);
        do_load("lwr2", 3'd6, 2'd2, 5'd10, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 0);
        do_load("lwr3", 3'd6, 2'd3, 5'd10, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11, 2);
        do_load("lh0",  3'd2, 2'd0, 5'd11, 1'b1, 32'h0, 32'h1234_8765, 32'hFFFF_8765, 1);
        do_load("lhu3", 3'd3, 2'd3, 5'd11, 1'b1, 32'h0, 32'h9ABC_0001, 32'h0000_9ABC, 1);
        do_load("lb1",  3'd0, 2'd1, 5'd12, 1'b1, 32'h0, 32'h0000_7F00, 32'h0000_007F, 1);
        do_load("lw2",  3'd4, 2'd2, 5'd12, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        do_load("rsv7", 3'd7, 2'd1, 5'd12, 1'b1, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);

        // Zero-wait LH
        do_load("lh_zw", 3'd2, 2'd2, 5'd13, 1'b1, 32'h0, 32'h8001_0000, 32'hFFFF_8001, 0);

        // Flush drops the presented instruction
        bus.mem_valid_i = 1'b1;
        bus.flush_i     = 1'b1;
        bus.mem_wreg_i  = 1'b1;
        bus.mem_waddr_i = 5'd7;
        bus.mem_wdata_i = 32'h77;
        cyc();
        idle_inputs();
        chk("flush_we", 32'(bus.write_en_o), 32'd0);
        chk("flush_ready", 32'(bus.mem_ready_o), 32'd1);
        cyc();
        chk("flush_we2", 32'(bus.write_en_o), 32'd0);

        // $0 and wreg=0
        drive_alu(5'd0, 32'h55);
        cyc();
        idle_inputs();
        chk("r0_we", 32'(bus.write_en_o), 32'd0);
        chk("r0_ready", 32'(bus.mem_ready_o), 32'd1);
        do_load("nowreg", 3'd4, 2'd0, 5'd9, 1'b0, 32'h0, 32'h1234_5678, 32'h1234_5678, 2);

        // ALU accepted from WRITE immediately followed by a load
        drive_alu(5'd14, 32'hA5A5_0001);
        cyc();
        chk("alu_then_load_we", 32'(bus.write_en_o), 32'd1);
        do_load("b2b_lw", 3'd4, 2'd0, 5'd15, 1'b1, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1);

        // Reset while a load is outstanding
        bus.mem_valid_i     = 1'b1;
        bus.mem_load_i      = 1'b1;
        bus.mem_wreg_i      = 1'b1;
        bus.mem_waddr_i     = 5'd6;
        bus.mem_load_type_i = 3'd4;
        cyc();
        idle_inputs();
        chk("rl_stall", 32'(bus.stall_req_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rl_ready", 32'(bus.mem_ready_o), 32'd1);
        chk("rl_stall0", 32'(bus.stall_req_o), 32'd0);
        chk("rl_we", 32'(bus.write_en_o), 32'd0);
        chk("rl_addr", 32'(bus.write_addr_o), 32'd0);
        chk("rl_data", bus.write_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i  = 32'hFFFF_FFFF;
        cyc();
        idle_inputs();
        chk("rl_stray_we", 32'(bus.write_en_o), 32'd0);
        chk("rl_stray_ready", 32'(bus.mem_ready_o), 32'd1);
        cyc();
        chk("rl_stray_we2", 32'(bus.write_en_o), 32'd0);

        chk("sb_empty", 32'(exp_addr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
